lsu_mem_stage: RTL
==================

# lsu_mem_stage

Parametrised memory-access stage for the RISC-V pipeline, sitting between EX/M and WB. It replaces single-cycle bus access with a request/response handshake to the data bus. It stalls the pipeline while a transaction is outstanding, detects misaligned and faulting accesses, and registers the aligned, sign-/zero-extended result into the W-stage outputs.

## Interface
**Parameters**
- `XLEN`, default 64: data width, 32 or 64.
- `ADDR_W`, default 64: address width.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: M stage holds a valid instruction.
- `flushM`, in, 1: kill the M-stage instruction.
- `stall_in`, in, 1: downstream/hazard stall; W registers hold.
- `mem_func`, in, 11: one-hot {LB,LBU,LH,LHU,LW,LWU,LD,SB,SH,SW,SD}, bit 10 = LB.
- `addr`, in, ADDR_W: effective address.
- `wdata`, in, XLEN: store data, LSB-aligned.
- `rd_we_in`, in, 1: rd write enable.
- `rd_addr_in`, in, 5: rd index.
- `rd_data_in`, in, XLEN: non-memory result.
- `stall_req`, out, 1: freeze F..M.
- `bus_req_valid`, out, 1: request valid.
- `bus_req_ready`, in, 1: request accepted.
- `bus_req_we`, out, 1: 1 = store.
- `bus_req_addr`, out, ADDR_W: addr with low log2(XLEN/8) bits zeroed.
- `bus_req_wdata`, out, XLEN: lane-shifted store data.
- `bus_req_wstrb`, out, XLEN/8: byte strobes.
- `bus_resp_valid`, in, 1: response valid; always accepted.
- `bus_resp_data`, in, XLEN: read data.
- `bus_resp_err`, in, 1: access fault.
- `out_valid`, out, 1: W-stage holds a valid instruction.
- `out_rd_we`, out, 1: W-stage rd write enable.
- `out_rd_addr`, out, 5: W-stage rd index.
- `out_rd_data`, out, XLEN: W-stage rd data.
- `exc_valid`, out, 1: W-stage exception.
- `exc_cause`, out, 4: 0=illegal, 4=load misaligned, 5=load fault, 6=store misaligned, 7=store fault.
- `exc_tval`, out, ADDR_W: faulting address.

## Operation
- **Reset.** State IDLE. Kill flag cleared. All outputs 0, including `bus_req_*` and every `out_*`/`exc_*` output.
- **Memory op.** A memory op exists when `in_valid & |mem_func`. Loads are bits 10..4; stores are bits 3..0.
- **Misalignment.**
  - Halfword: `addr[0]` ≠ 0.
  - Word: `addr[1:0]` ≠ 0.
  - Double: `addr[2:0]` ≠ 0.
  - A misaligned access makes no bus request. The instruction goes to W with `exc_valid`=1, cause 4 or 6, `tval=addr`, and `out_rd_we`=0.
- **XLEN=32.** LD, LWU and SD produce cause 0 with no bus request.
- **Store formatting.** Offset `o = addr[log2(XLEN/8)-1:0]`.
  - `wdata` is shifted left by `8*o`.
  - `wstrb` is 1, 3, 0xF or 0xFF shifted left by `o`.
- **Load formatting.** Response data is shifted right by `8*o`, truncated to the access size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU). LD passes through unchanged.
- **FSM.**
  - IDLE → REQ when an aligned, legal memory op is present and `!flushM`. Request fields are latched on this edge.
  - REQ holds `bus_req_valid`=1 with stable fields until `bus_req_ready`, then → RESP.
  - RESP → IDLE on `bus_resp_valid`.
- **stall_req** = (IDLE & starting) | REQ | (RESP & !bus_resp_valid). This is combinational.
- **W registers.**
  - Update when `!stall_in & !stall_req`.
  - Load data comes from `bus_resp_data` in the completing cycle. Otherwise the value is `rd_data_in`.
  - Stores write `out_rd_we`=0.
  - `bus_resp_err` → cause 5 or 7, `tval` = latched address, `out_rd_we`=0.
- **Flush, no transaction outstanding.** `flushM` in IDLE loads a bubble into W: all `out_*`/`exc_*` = 0.
- **Flush, transaction outstanding.** `flushM` in REQ or RESP sets the kill flag.
  - The transaction completes on the bus, because valid is never dropped before ready.
  - The response is discarded and W receives a bubble.
  - `stall_req` stays asserted until the response arrives.
- **Reset mid-transaction.** Immediate return to IDLE. The bus side is reset concurrently.

## Timing
- **Zero-wait load.**
  - Cycle 0: op in M, `stall_req`=1.
  - Cycle 1: `bus_req_valid`=1, ready=1.
  - Cycle 2: `bus_resp_valid`=1, `stall_req`=0.
  - Cycle 3: `out_valid`=1 with data.
- **Wait states.** Each cycle of `bus_req_ready`=0 or `bus_resp_valid`=0 adds one cycle.
- **Non-memory ops** have 1-cycle latency M→W with no stall.
- **Exceptions** (misaligned/illegal) have 1-cycle latency with no stall.
- **Overlap.** Response and request never overlap: at most one outstanding transaction.
- **Stall priority.** If `stall_in`=1 in the completing cycle, the FSM still returns to IDLE. The response is held in a one-entry result register and written to W when `stall_in` falls.

## Structure
- **`lsu_pkg`:**
  - `mem_func` bit-index constants.
  - Exception cause constants.
  - FSM state enum (IDLE, REQ, RESP).
- **`lsu_align` sub-module (combinational):**
  - Store shift and strobe generation.
  - Load extract and extend.
  - Misalignment and illegal detect.

## Test plan
- **Aligned LD.** XLEN=64, LD @0x80000008, resp 0x1122334455667788 → `out_rd_data`=0x1122334455667788 at cycle 3; `stall_req` high for cycles 0–1.
- **LB sign-extend.** LB @0x80000003, resp 0x00000000_80FF0000 → data = 0xFFFFFFFFFFFFFF80. LBU @0x80000002 on the same response → 0xFF.
- **SH strobes.** SH @0x80000006, `wdata`=0xABCD → `wstrb`=0xC0, `wdata`=0xABCD000000000000. `bus_req_valid` holds for 3 cycles while ready=0.
- **Misaligned LW.** LW @0x80000002 → no `bus_req_valid`; `exc_valid`=1, cause 4, `tval`=0x80000002, `out_rd_we`=0, no stall.
- **Flush in RESP.** `flushM` pulsed while in RESP → stall held until response, then W is a bubble (`out_valid`=0) and no register write.
- **Bus error.** SW with `bus_resp_err`=1 → cause 7. Separately, `rst_n` low during REQ → all outputs 0 and state IDLE immediately.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the memory-access stage:
//   - bit positions of the one-hot mem_func vector (bit 10 = LB ... bit 0 = SD)
//   - exception cause codes reported to the W stage
//   - bus transaction FSM state encoding
//   - small helper to classify a mem_func vector as a load
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam int F_LB  = 10;
    localparam int F_LBU = 9;
    localparam int F_LH  = 8;
    localparam int F_LHU = 7;
    localparam int F_LW  = 6;
    localparam int F_LWU = 5;
    localparam int F_LD  = 4;
    localparam int F_SB  = 3;
    localparam int F_SH  = 2;
    localparam int F_SW  = 1;
    localparam int F_SD  = 0;

    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd0;
    localparam logic [3:0] CAUSE_LD_MISAL = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISAL = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    function automatic logic is_load_op(input logic [10:0] func);
        return |func[F_LB:F_LD];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational data formatting for the memory stage.
//   Request side (current M-stage instruction):
//     req_func, req_off, req_wdata -> is_load, is_store, misaligned, illegal,
//                                     st_data (lane-shifted), st_strb
//   Response side (latched transaction):
//     resp_func, resp_off, resp_data -> ld_data (extracted and extended)
// Offsets are the low three address bits; only the low log2(XLEN/8) of them
// select a byte lane.
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [10:0]       req_func,
    input  logic [2:0]        req_off,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [10:0]       resp_func,
    input  logic [2:0]        resp_off,
    input  logic [XLEN-1:0]   resp_data,
    output logic              is_load,
    output logic              is_store,
    output logic              misaligned,
    output logic              illegal,
    output logic [XLEN-1:0]   st_data,
    output logic [XLEN/8-1:0] st_strb,
    output logic [XLEN-1:0]   ld_data
);

    // On a 32-bit datapath bit 2 of the address is not a lane select.
    localparam logic [2:0] LANE_MASK = (XLEN == 64) ? 3'b111 : 3'b011;

    logic [2:0]      req_lane;
    logic [2:0]      resp_lane;
    logic [7:0]      strb_base;
    logic [7:0]      strb_shifted;
    logic [XLEN-1:0] resp_shifted;

    assign req_lane  = req_off & LANE_MASK;
    assign resp_lane = resp_off & LANE_MASK;

    // Classify the request and check natural alignment against the raw
    // address bits; doubleword ops do not exist on a 32-bit datapath.
    always_comb begin
        is_load    = is_load_op(req_func);
        is_store   = |req_func[F_SB:F_SD];
        illegal    = (XLEN == 32) && (req_func[F_LD] || req_func[F_LWU] || req_func[F_SD]);
        misaligned = ((req_func[F_LH] || req_func[F_LHU] || req_func[F_SH]) && req_off[0])
                  || ((req_func[F_LW] || req_func[F_LWU] || req_func[F_SW]) && (req_off[1:0] != 2'b00))
                  || ((req_func[F_LD] || req_func[F_SD]) && (req_off != 3'b000));
    end

    // Store formatting: move data into its byte lane and build the matching
    // strobe; the strobe is built on 8 bits and trimmed to the bus width.
    always_comb begin
        strb_base = 8'h00;
        if (req_func[F_SB]) strb_base = 8'h01;
        if (req_func[F_SH]) strb_base = 8'h03;
        if (req_func[F_SW]) strb_base = 8'h0F;
        if (req_func[F_SD]) strb_base = 8'hFF;
        strb_shifted = strb_base << req_lane;
        st_strb      = strb_shifted[XLEN/8-1:0];
        st_data      = req_wdata << {req_lane, 3'b000};
    end

    // Load formatting: bring the addressed lane down to bit 0, then truncate
    // and sign- or zero-extend by access size. LD passes the word unchanged.
    always_comb begin
        resp_shifted = resp_data >> {resp_lane, 3'b000};
        ld_data      = resp_shifted;
        if (resp_func[F_LB])  ld_data = XLEN'($signed(resp_shifted[7:0]));
        if (resp_func[F_LBU]) ld_data = XLEN'(resp_shifted[7:0]);
        if (resp_func[F_LH])  ld_data = XLEN'($signed(resp_shifted[15:0]));
        if (resp_func[F_LHU]) ld_data = XLEN'(resp_shifted[15:0]);
        if (resp_func[F_LW])  ld_data = XLEN'($signed(resp_shifted[31:0]));
        if (resp_func[F_LWU]) ld_data = XLEN'(resp_shifted[31:0]);
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
// Memory-access stage between EX/M and WB using a valid/ready request and
// an always-accepted response channel. At most one transaction is in flight.
//   Pipeline in : in_valid, flushM, stall_in, mem_func, addr, wdata,
//                 rd_we_in, rd_addr_in, rd_data_in
//   Pipeline out: stall_req (combinational freeze of F..M)
//   Bus request : bus_req_valid/ready, bus_req_we, bus_req_addr (lane bits
//                 zeroed), bus_req_wdata, bus_req_wstrb
//   Bus response: bus_resp_valid, bus_resp_data, bus_resp_err
//   W stage     : out_valid, out_rd_we, out_rd_addr, out_rd_data,
//                 exc_valid, exc_cause, exc_tval
// ---------------------------------------------------------------------------
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              flushM,
    input  logic              stall_in,
    input  logic [10:0]       mem_func,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              rd_we_in,
    input  logic [4:0]        rd_addr_in,
    input  logic [XLEN-1:0]   rd_data_in,
    output logic              stall_req,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [XLEN-1:0]   bus_req_wdata,
    output logic [XLEN/8-1:0] bus_req_wstrb,
    input  logic              bus_resp_valid,
    input  logic [XLEN-1:0]   bus_resp_data,
    input  logic              bus_resp_err,
    output logic              out_valid,
    output logic              out_rd_we,
    output logic [4:0]        out_rd_addr,
    output logic [XLEN-1:0]   out_rd_data,
    output logic              exc_valid,
    output logic [3:0]        exc_cause,
    output logic [ADDR_W-1:0] exc_tval
);

    localparam int LANE_BITS = $clog2(XLEN/8);

    lsu_state_e state_q, state_d;
    logic       kill_q;

    logic              lat_we;
    logic [10:0]       lat_func;
    logic [ADDR_W-1:0] lat_addr;
    logic [XLEN-1:0]   lat_wdata;
    logic [XLEN/8-1:0] lat_wstrb;
    logic              lat_rd_we;
    logic [4:0]        lat_rd_addr;

    logic              hold_valid;
    logic              h_valid;
    logic              h_rd_we;
    logic [4:0]        h_rd_addr;
    logic [XLEN-1:0]   h_rd_data;
    logic              h_exc;
    logic [3:0]        h_cause;
    logic [ADDR_W-1:0] h_tval;

    logic              w_valid;
    logic              w_rd_we;
    logic [4:0]        w_rd_addr;
    logic [XLEN-1:0]   w_rd_data;
    logic              w_exc;
    logic [3:0]        w_cause;
    logic [ADDR_W-1:0] w_tval;

    logic              op_load, op_store, op_misal, op_illegal;
    logic [XLEN-1:0]   st_data, ld_data;
    logic [XLEN/8-1:0] st_strb;
    logic              start, resp_done, w_en;

    lsu_align #(.XLEN(XLEN)) u_align (
        .req_func   (mem_func),
        .req_off    (addr[2:0]),
        .req_wdata  (wdata),
        .resp_func  (lat_func),
        .resp_off   (lat_addr[2:0]),
        .resp_data  (bus_resp_data),
        .is_load    (op_load),
        .is_store   (op_store),
        .misaligned (op_misal),
        .illegal    (op_illegal),
        .st_data    (st_data),
        .st_strb    (st_strb),
        .ld_data    (ld_data)
    );

    // A bus transaction starts only from IDLE for a legal, aligned memory op
    // that is not being flushed. A pending held result blocks a restart of
    // the instruction it belongs to while the pipeline is still frozen.
    assign start     = (state_q == ST_IDLE) && in_valid && (|mem_func)
                    && !op_misal && !op_illegal && !flushM && !hold_valid;
    assign resp_done = (state_q == ST_RESP) && bus_resp_valid;
    assign w_en      = !stall_in && !stall_req;

    assign bus_req_valid = (state_q == ST_REQ);
    assign bus_req_we    = lat_we;
    assign bus_req_addr  = {lat_addr[ADDR_W-1:LANE_BITS], {LANE_BITS{1'b0}}};
    assign bus_req_wdata = lat_wdata;
    assign bus_req_wstrb = lat_wstrb;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pipeline stall. The stall drops in the cycle the
    // response arrives so the W registers can capture it on that edge.
    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_REQ;
                    stall_req = 1'b1;
                end
            end
            ST_REQ: begin
                stall_req = 1'b1;
                if (bus_req_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus_resp_valid) state_d = ST_IDLE;
                else                stall_req = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Kill flag: a flush that lands while the bus is busy cannot cancel the
    // handshake, so it is remembered and applied to the response instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_q <= 1'b0;
        end else if (resp_done) begin
            kill_q <= 1'b0;
        end else if (flushM && (state_q != ST_IDLE)) begin
            kill_q <= 1'b1;
        end
    end

    // Request fields are captured once on entry to REQ and held stable until
    // the next transaction; loads carry no write data or strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we      <= 1'b0;
            lat_func    <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_wstrb   <= '0;
            lat_rd_we   <= 1'b0;
            lat_rd_addr <= '0;
        end else if (start) begin
            lat_we      <= op_store;
            lat_func    <= mem_func;
            lat_addr    <= addr;
            lat_wdata   <= op_store ? st_data : '0;
            lat_wstrb   <= op_store ? st_strb : '0;
            lat_rd_we   <= rd_we_in;
            lat_rd_addr <= rd_addr_in;
        end
    end

    // Value headed for the W stage. A completing transaction wins, then a
    // held result, then whatever the M stage presents (bubble, exception or
    // plain ALU result). Exceptions never write rd.
    always_comb begin
        w_valid   = 1'b0;
        w_rd_we   = 1'b0;
        w_rd_addr = '0;
        w_rd_data = '0;
        w_exc     = 1'b0;
        w_cause   = '0;
        w_tval    = '0;
        if (resp_done) begin
            if (!kill_q && !flushM) begin
                w_valid   = 1'b1;
                w_rd_addr = lat_rd_addr;
                if (bus_resp_err) begin
                    w_exc   = 1'b1;
                    w_cause = lat_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                    w_tval  = lat_addr;
                end else if (lat_we) begin
                    w_rd_data = rd_data_in;
                end else begin
                    w_rd_we   = lat_rd_we;
                    w_rd_data = ld_data;
                end
            end
        end else if (hold_valid) begin
            w_valid   = h_valid;
            w_rd_we   = h_rd_we;
            w_rd_addr = h_rd_addr;
            w_rd_data = h_rd_data;
            w_exc     = h_exc;
            w_cause   = h_cause;
            w_tval    = h_tval;
        end else if (in_valid && !flushM) begin
            w_valid   = 1'b1;
            w_rd_addr = rd_addr_in;
            if (op_illegal) begin
                w_exc   = 1'b1;
                w_cause = CAUSE_ILLEGAL;
                w_tval  = addr;
            end else if (op_misal) begin
                w_exc   = 1'b1;
                w_cause = op_load ? CAUSE_LD_MISAL : CAUSE_ST_MISAL;
                w_tval  = addr;
            end else begin
                w_rd_we   = rd_we_in;
                w_rd_data = rd_data_in;
            end
        end
    end

    // W-stage registers advance only when neither downstream nor this stage
    // is stalling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_rd_we   <= 1'b0;
            out_rd_addr <= '0;
            out_rd_data <= '0;
            exc_valid   <= 1'b0;
            exc_cause   <= '0;
            exc_tval    <= '0;
        end else if (w_en) begin
            out_valid   <= w_valid;
            out_rd_we   <= w_rd_we;
            out_rd_addr <= w_rd_addr;
            out_rd_data <= w_rd_data;
            exc_valid   <= w_exc;
            exc_cause   <= w_cause;
            exc_tval    <= w_tval;
        end
    end

    // One-entry result buffer: a response that completes while downstream is
    // stalled is parked here (the FSM is already back in IDLE) and drained
    // into W on the first unstalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            h_valid    <= 1'b0;
            h_rd_we    <= 1'b0;
            h_rd_addr  <= '0;
            h_rd_data  <= '0;
            h_exc      <= 1'b0;
            h_cause    <= '0;
            h_tval     <= '0;
        end else if (w_en) begin
            hold_valid <= 1'b0;
        end else if (resp_done && stall_in) begin
            hold_valid <= 1'b1;
            h_valid    <= w_valid;
            h_rd_we    <= w_rd_we;
            h_rd_addr  <= w_rd_addr;
            h_rd_data  <= w_rd_data;
            h_exc      <= w_exc;
            h_cause    <= w_cause;
            h_tval     <= w_tval;
        end
    end

endmodule
